exibe_sequencia: RTL

Playback engine for the memory game: on a start request it reads the stored sequence from the synchronous 16x4 sequence ROM, address 0 through a sampled limit. Each entry is lit on the LED outputs for a fixed on-time, followed by a dark gap. It is the presenting end of the sequence interface: this block shows the ROM contents to the player, and the player-side datapath reads the same ROM to check the buttons pressed. It sits beside that datapath under the game control unit, which pulses `iniciar` and waits for `pronto`.

---
 rtl/exibe_sequencia_pkg.sv | 23 ++
 rtl/exibe_sequencia_if.sv | 25 ++
 rtl/exibe_sequencia_temporizador.sv | 29 ++
 rtl/exibe_sequencia.sv | 135 +++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence playback engine: state codes seen by
// game control and the debug 7-segment decoder, plus the timer sizing helper.
package exibe_sequencia_pkg;

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      CARREGA = 4'd1,
      LE      = 4'd2,
      ACENDE  = 4'd3,
      APAGA   = 4'd4,
      PROXIMO = 4'd5,
      FIM     = 4'd6
   } estado_t;

   // Timer width wide enough to hold the larger of T_ON-1 and T_OFF-1,
   // never narrower than one bit.
   function automatic int largura_timer(input int t_on, input int t_off);
      int maior;
      maior = (t_on > t_off) ? t_on : t_off;
      return (maior < 2) ? 1 : $clog2(maior);
   endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Sequence interface: start handshake and limit from game control, ROM
// address/data, LED outputs and debug state. The playback engine uses the
// slave view; game control / ROM side uses the master view.
interface exibe_sequencia_if;

   logic       iniciar;
   logic [3:0] limite;
   logic [3:0] dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;

   modport slave (
      input  iniciar, limite, dado,
      output endereco, leds, ocupado, pronto, db_estado
   );

   modport master (
      output iniciar, limite, dado,
      input  endereco, leds, ocupado, pronto, db_estado
   );

endinterface

// File: rtl/exibe_sequencia_temporizador.sv
// Loadable down-counter used to time the lit and dark phases of each entry.
// Expiry is a count of zero; the count stops there until reloaded.
module temporizador #(
   parameter int LARGURA = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               carrega,
   input  logic               conta,
   input  logic [LARGURA-1:0] valor,
   output logic               fim
);

   logic [LARGURA-1:0] contagem;

   // Load has priority over counting; reset clears the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         contagem <= '0;
      end else if (carrega) begin
         contagem <= valor;
      end else if (conta && (contagem != '0)) begin
         contagem <= contagem - LARGURA'(1);
      end
   end

   assign fim = (contagem == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Playback engine for the memory game: walks the sequence ROM from address 0
// up to the sampled limit, lighting each entry for T_ON cycles followed by a
// T_OFF-cycle dark gap, then pulses pronto for game control.
module exibe_sequencia
   import exibe_sequencia_pkg::*;
#(
   parameter int T_ON  = 500,
   parameter int T_OFF = 250
) (
   input  logic                clock,
   input  logic                reset,
   exibe_sequencia_if.slave    bus
);

   localparam int LT = largura_timer(T_ON, T_OFF);
   localparam logic [LT-1:0] CARGA_ON  = LT'(T_ON - 1);
   localparam logic [LT-1:0] CARGA_OFF = LT'(T_OFF - 1);

   estado_t          estado;
   estado_t          proximo_estado;
   logic [3:0]       endereco_r;
   logic [3:0]       lim_r;
   logic [3:0]       leds_r;
   logic             carrega_t;
   logic             conta_t;
   logic [LT-1:0]    valor_t;
   logic             fim_t;

   temporizador #(.LARGURA(LT)) u_temporizador (
      .clock   (clock),
      .reset   (reset),
      .carrega (carrega_t),
      .conta   (conta_t),
      .valor   (valor_t),
      .fim     (fim_t)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= INICIAL;
      end else begin
         estado <= proximo_estado;
      end
   end

   // Next-state and timer control: CARREGA gives the ROM its latency cycle,
   // LE captures the data and arms the lit phase.
   always_comb begin
      proximo_estado = estado;
      carrega_t      = 1'b0;
      conta_t        = 1'b0;
      valor_t        = CARGA_ON;
      case (estado)
         INICIAL: begin
            if (bus.iniciar) begin
               proximo_estado = CARREGA;
            end
         end
         CARREGA: begin
            proximo_estado = LE;
         end
         LE: begin
            carrega_t      = 1'b1;
            valor_t        = CARGA_ON;
            proximo_estado = ACENDE;
         end
         ACENDE: begin
            if (fim_t) begin
               carrega_t      = 1'b1;
               valor_t        = CARGA_OFF;
               proximo_estado = APAGA;
            end else begin
               conta_t = 1'b1;
            end
         end
         APAGA: begin
            if (fim_t) begin
               proximo_estado = PROXIMO;
            end else begin
               conta_t = 1'b1;
            end
         end
         PROXIMO: begin
            if (endereco_r == lim_r) begin
               proximo_estado = FIM;
            end else begin
               proximo_estado = CARREGA;
            end
         end
         FIM: begin
            proximo_estado = INICIAL;
         end
         default: begin
            proximo_estado = INICIAL;
         end
      endcase
   end

   // Address counter, sampled limit and displayed entry; the address is left
   // at its last value after a run so the datapath can still see it.
   always_ff @(posedge clock) begin
      if (reset) begin
         endereco_r <= 4'd0;
         lim_r      <= 4'd0;
         leds_r     <= 4'd0;
      end else begin
         case (estado)
            INICIAL: begin
               if (bus.iniciar) begin
                  lim_r      <= bus.limite;
                  endereco_r <= 4'd0;
               end
            end
            LE: begin
               leds_r <= bus.dado;
            end
            PROXIMO: begin
               if (endereco_r != lim_r) begin
                  endereco_r <= endereco_r + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.endereco  = endereco_r;
   assign bus.leds      = (estado == ACENDE) ? leds_r : 4'd0;
   assign bus.ocupado   = (estado != INICIAL);
   assign bus.pronto    = (estado == FIM);
   assign bus.db_estado = estado;

endmodule
